// File: rtl/sdio_ram_pkg.sv
// Shared constants for the SDIO buffer-RAM arbiter: default geometry, port IDs, byte enables.
package sdio_ram_pkg;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 18;
  localparam int MAX_LOCK_DEF = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_ALL  = 2'b11;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sdio_ram_rr_arb.sv
// Two-way round-robin grant with a rotating priority pointer.
// With SDIO_RAM_ARB_LOCK_EN defined, an owner may lock the grant for up to MAX_LOCK cycles.
module sdio_ram_rr_arb
  import sdio_ram_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic a_req,
  input  logic b_req,
`ifdef SDIO_RAM_ARB_LOCK_EN
  input  logic a_lock,
  input  logic b_lock,
`endif
  output logic a_gnt,
  output logic b_gnt
);

  port_e ptr_q, ptr_d;
  logic  a_rr, b_rr;

`ifdef SDIO_RAM_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  port_e         owner_q, owner_d;
  logic          own_req, own_lock, oth_req, hold, forced;
  logic          gnt_lock;
  port_e         gnt_port;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q <= PORT_A;
`ifdef SDIO_RAM_ARB_LOCK_EN
      cnt_q   <= '0;
      owner_q <= PORT_A;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef SDIO_RAM_ARB_LOCK_EN
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`endif
    end
  end

  // Grants are combinational so a requester is served in the cycle it asks.
  always_comb begin
    a_rr  = a_req && (!b_req || (ptr_q == PORT_A));
    b_rr  = b_req && !a_rr;
    a_gnt = a_rr;
    b_gnt = b_rr;
`ifdef SDIO_RAM_ARB_LOCK_EN
    own_req  = (owner_q == PORT_A) ? a_req  : b_req;
    own_lock = (owner_q == PORT_A) ? a_lock : b_lock;
    oth_req  = (owner_q == PORT_A) ? b_req  : a_req;
    forced   = (cnt_q == CW'(MAX_LOCK));
    hold     = (cnt_q != '0) && !forced && own_req && own_lock;
    if (hold || (forced && !oth_req)) begin
      a_gnt = (owner_q == PORT_A) && own_req;
      b_gnt = (owner_q == PORT_B) && own_req;
    end else if (forced) begin
      a_gnt = (owner_q == PORT_B);
      b_gnt = (owner_q == PORT_A);
    end
`endif
    if (Rst) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (a_gnt) begin
      ptr_d = PORT_B;
    end else if (b_gnt) begin
      ptr_d = PORT_A;
    end
`ifdef SDIO_RAM_ARB_LOCK_EN
    gnt_port = b_gnt ? PORT_B : PORT_A;
    gnt_lock = b_gnt ? b_lock : a_lock;
    owner_d  = (a_gnt || b_gnt) ? gnt_port : owner_q;
    cnt_d    = cnt_q;
    if (hold) begin
      ptr_d = ptr_q;
    end
    if (forced) begin
      cnt_d = '0;
    end else if (a_gnt || b_gnt) begin
      if (!gnt_lock) begin
        cnt_d = '0;
      end else if (gnt_port == owner_q) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = CW'(1);
      end
    end else if (!own_lock) begin
      cnt_d = '0;
    end
`endif
  end

endmodule

// File: rtl/sdio_ram_arbiter.sv
// Buffer-RAM sequencer: muxes the granted port onto the RAM and returns read data one cycle later.
// Optional grant locking is enabled by defining SDIO_RAM_ARB_LOCK_EN.
module sdio_ram_arbiter
  import sdio_ram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [1:0]    a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
`ifdef SDIO_RAM_ARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [1:0]    b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_wa,
  output logic [AW-1:0] ram_ra,
  output logic [DW-1:0] ram_wd,
  output logic [1:0]    ram_wen,
  output logic          ram_wd_sel,
  output logic          ram_rd_sel,
  input  logic [DW-1:0] ram_rd
);

  logic          gnt_any, sel_we;
  logic [1:0]    sel_be;
  logic [AW-1:0] sel_addr;
  logic          rd_issued_q, rd_issued_d;
  port_e         rd_owner_q, rd_owner_d;
  logic          rd_vld;

  sdio_ram_rr_arb #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .Clk    (Clk),
    .Rst    (Rst),
    .a_req  (a_req),
    .b_req  (b_req),
`ifdef SDIO_RAM_ARB_LOCK_EN
    .a_lock (a_lock),
    .b_lock (b_lock),
`endif
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  // Address and data simply follow the mux; only the strobes mark a real access.
  always_comb begin
    gnt_any     = a_gnt | b_gnt;
    sel_we      = b_gnt ? b_we   : a_we;
    sel_be      = b_gnt ? b_be   : a_be;
    sel_addr    = b_gnt ? b_addr : a_addr;
    ram_wa      = sel_addr;
    ram_ra      = sel_addr;
    ram_wd      = b_gnt ? b_wdata : a_wdata;
    ram_wd_sel  = gnt_any & sel_we;
    ram_wen     = ram_wd_sel ? sel_be : BE_NONE;
    rd_issued_d = gnt_any & ~sel_we;
    rd_owner_d  = b_gnt ? PORT_B : PORT_A;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_issued_q <= 1'b0;
      rd_owner_q  <= PORT_A;
    end else begin
      rd_issued_q <= rd_issued_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // A return still in flight when reset arrives is dropped immediately.
  always_comb begin
    rd_vld     = rd_issued_q & ~Rst;
    ram_rd_sel = rd_vld;
    a_rvalid   = rd_vld && (rd_owner_q == PORT_A);
    b_rvalid   = rd_vld && (rd_owner_q == PORT_B);
    rdata      = rd_vld ? ram_rd : '0;
  end

endmodule

// File: tb/tb_sdio_ram_arbiter.sv
// Scoreboard bench for sdio_ram_arbiter with a behavioural 256x18 byte-enabled RAM.
module tb_sdio_ram_arbiter;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  wen;
    logic        wdSel;
    logic        rd;
    logic [7:0]  addr;
    logic [17:0] wd;
  } expCyc_t;

  typedef struct {
    logic        port;
    logic [17:0] data;
  } expRd_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_be, b_be;
  logic [7:0]  a_addr, b_addr;
  logic [17:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [17:0] rdata;
  logic [7:0]  ram_wa, ram_ra;
  logic [17:0] ram_wd;
  logic [1:0]  ram_wen;
  logic        ram_wd_sel, ram_rd_sel;
  logic [17:0] ram_rd = 18'h0;
  logic [17:0] mem [256] = '{default: 18'h0};

  int vectors = 0;
  int miscompares = 0;
  expCyc_t expQ[$];
  expRd_t  rdQ[$];
  expCyc_t mE;
  expRd_t  mR;

  always #5 Clk = ~Clk;

  sdio_ram_arbiter dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_be       (a_be),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_be       (b_be),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .rdata      (rdata),
    .ram_wa     (ram_wa),
    .ram_ra     (ram_ra),
    .ram_wd     (ram_wd),
    .ram_wen    (ram_wen),
    .ram_wd_sel (ram_wd_sel),
    .ram_rd_sel (ram_rd_sel),
    .ram_rd     (ram_rd)
  );

  // Synchronous-read RAM macro model with per-half write enables.
  always @(posedge Clk) begin
    if (ram_wd_sel === 1'b1) begin
      if (ram_wen[0] === 1'b1) mem[ram_wa][8:0]  <= ram_wd[8:0];
      if (ram_wen[1] === 1'b1) mem[ram_wa][17:9] <= ram_wd[17:9];
    end
    ram_rd <= mem[ram_ra];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic rst,
    input logic aReq, input logic aWe, input logic [1:0] aBe, input logic [7:0] aAddr, input logic [17:0] aWd,
    input logic bReq, input logic bWe, input logic [1:0] bBe, input logic [7:0] bAddr, input logic [17:0] bWd,
    input logic [1:0] expGnt, input logic rdRet, input logic [17:0] expRd
  );
    expCyc_t e;
    expRd_t  r;
    Rst = rst;
    a_req = aReq; a_we = aWe; a_be = aBe; a_addr = aAddr; a_wdata = aWd;
    b_req = bReq; b_we = bWe; b_be = bBe; b_addr = bAddr; b_wdata = bWd;
    e.gnt = expGnt; e.wen = 2'b00; e.wdSel = 1'b0; e.rd = 1'b0; e.addr = 8'h0; e.wd = 18'h0;
    if (expGnt == 2'b01) begin
      if (aWe) begin e.wen = aBe; e.wdSel = 1'b1; e.addr = aAddr; e.wd = aWd; end
      else begin e.rd = 1'b1; e.addr = aAddr; end
    end else if (expGnt == 2'b10) begin
      if (bWe) begin e.wen = bBe; e.wdSel = 1'b1; e.addr = bAddr; e.wd = bWd; end
      else begin e.rd = 1'b1; e.addr = bAddr; end
    end
    expQ.push_back(e);
    if (e.rd && rdRet) begin
      r.port = expGnt[1];
      r.data = expRd;
      rdQ.push_back(r);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 0, 0, 2'b00, 8'h00, 18'h0, 0, 0, 2'b00, 8'h00, 18'h0, 2'b00, 0, 18'h0);
  endtask

  // Monitor: compares every driven cycle and every read return against the queues.
  always @(negedge Clk) begin
    checkOutput("no_double_gnt", 32'(a_gnt & b_gnt), 32'd0);
    if (expQ.size() != 0) begin
      mE = expQ.pop_front();
      checkOutput("gnt", 32'({b_gnt, a_gnt}), 32'(mE.gnt));
      checkOutput("ram_wen", 32'(ram_wen), 32'(mE.wen));
      checkOutput("ram_wd_sel", 32'(ram_wd_sel), 32'(mE.wdSel));
      if (mE.wdSel) begin
        checkOutput("ram_wa", 32'(ram_wa), 32'(mE.addr));
        checkOutput("ram_wd", 32'(ram_wd), 32'(mE.wd));
      end
      if (mE.rd) checkOutput("ram_ra", 32'(ram_ra), 32'(mE.addr));
    end
    if ((a_rvalid | b_rvalid) === 1'b1) begin
      if (rdQ.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'({b_rvalid, a_rvalid}), 32'd0);
      end else begin
        mR = rdQ.pop_front();
        checkOutput("rvalid_owner", 32'({b_rvalid, a_rvalid}), mR.port ? 32'd2 : 32'd1);
        checkOutput("rdata", 32'(rdata), 32'(mR.data));
        checkOutput("ram_rd_sel", 32'(ram_rd_sel), 32'd1);
      end
    end else begin
      checkOutput("rdata_idle", 32'(rdata), 32'd0);
      checkOutput("rd_sel_idle", 32'(ram_rd_sel), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst = 1'b1;
    a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    @(posedge Clk);
    #1;
    // Reset held with A requesting: nothing may be granted.
    applyStimulus(1, 1, 1, 2'b11, 8'h10, 18'h2ABCD, 0, 0, 2'b00, 8'h00, 18'h0, 2'b00, 0, 18'h0);
    applyStimulus(1, 1, 1, 2'b11, 8'h10, 18'h2ABCD, 0, 0, 2'b00, 8'h00, 18'h0, 2'b00, 0, 18'h0);
    applyStimulus(0, 1, 1, 2'b11, 8'h10, 18'h2ABCD, 0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 0, 18'h0);
    applyStimulus(0, 1, 0, 2'b00, 8'h10, 18'h0,     0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 1, 18'h2ABCD);
    idle(0);
    // B writes the high half only: 0x15555 keeps bits [17:9] -> 0x15400.
    applyStimulus(0, 0, 0, 2'b00, 8'h00, 18'h0, 1, 1, 2'b10, 8'h20, 18'h15555, 2'b10, 0, 18'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 2'b00, 8'h10, 18'h0, 1, 0, 2'b00, 8'h20, 18'h0, 2'b01, 1, 18'h2ABCD);
      applyStimulus(0, 1, 0, 2'b00, 8'h10, 18'h0, 1, 0, 2'b00, 8'h20, 18'h0, 2'b10, 1, 18'h15400);
    end
    // Low-half write over zero, then a be=00 write that must not disturb it.
    applyStimulus(0, 1, 1, 2'b01, 8'h05, 18'h3FFFF, 0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 0, 18'h0);
    applyStimulus(0, 1, 0, 2'b00, 8'h05, 18'h0,     0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 1, 18'h001FF);
    applyStimulus(0, 1, 1, 2'b00, 8'h05, 18'h0,     0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 0, 18'h0);
    applyStimulus(0, 1, 0, 2'b00, 8'h05, 18'h0,     0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 1, 18'h001FF);
    // B read followed by reset: its return must never appear.
    applyStimulus(0, 0, 0, 2'b00, 8'h00, 18'h0, 1, 0, 2'b00, 8'h05, 18'h0, 2'b10, 0, 18'h0);
    idle(1);
    // Leave the pointer at B, reset, then both request: A must win.
    applyStimulus(0, 1, 1, 2'b11, 8'h30, 18'h00155, 0, 0, 2'b00, 8'h00, 18'h0, 2'b01, 0, 18'h0);
    idle(1);
    applyStimulus(0, 1, 0, 2'b00, 8'h30, 18'h0, 1, 0, 2'b00, 8'h10, 18'h0, 2'b01, 1, 18'h00155);
    applyStimulus(0, 0, 0, 2'b00, 8'h00, 18'h0, 1, 0, 2'b00, 8'h10, 18'h0, 2'b10, 1, 18'h2ABCD);
    idle(0);
    idle(0);
    checkOutput("cycle_queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("read_queue_drained", 32'(rdQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdio_ram_arbiter.md
Name: sdio_ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the SDIO controller's 256x18 buffer RAM macro.
- Port A is the SDIO data-path FIFO engine; port B is the host/AHB-side buffer access.
- Grants at most one access per cycle and drives the RAM write/read address, data, byte-enable and select strobes.
- Returns read data with a fixed one-cycle latency and a per-requester valid flag.

Parameters:
- AW, 8, RAM address width (256 words).
- DW, 18, RAM data width.
- MAX_LOCK, 16, maximum consecutive locked grants before forced release (used only with the optional feature).

Ports:
- Clk  input  1  single system clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- a_req  input  1  port A access request.
- a_we  input  1  port A write (1) / read (0).
- a_be  input  2  port A byte enables (bit0 = [8:0], bit1 = [17:9]).
- a_addr  input  AW  port A word address.
- a_wdata  input  DW  port A write data.
- a_gnt  output  1  port A granted this cycle (combinational).
- a_rvalid  output  1  port A read data valid on rdata.
- b_req, b_we, b_be, b_addr, b_wdata, b_gnt, b_rvalid: same as port A, for port B.
- rdata  output  DW  shared read data return.
- ram_wa  output  AW  RAM write address.
- ram_ra  output  AW  RAM read address.
- ram_wd  output  DW  RAM write data.
- ram_wen  output  2  RAM byte write enables.
- ram_wd_sel  output  1  RAM write select.
- ram_rd_sel  output  1  RAM read output enable.
- ram_rd  input  DW  RAM read data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Clock port is Clk, reset port is Rst.
- Reset values: priority pointer = A; a_rvalid = b_rvalid = 0; rd-issued flag = 0; lock counter = 0. Hence ram_rd_sel = 0 and rdata = 0. With no request, ram_wen = 0 and ram_wd_sel = 0.
- Arbitration: combinational, same cycle as req.
  - Only one port requests: that port is granted.
  - Both request: the port selected by the priority pointer is granted.
  - After any grant, the pointer moves to the other port. With no grant, the pointer holds.
  - a_gnt and b_gnt are never both 1.
- Granted write:
  - ram_wa = addr, ram_wd = wdata, ram_wen = be, ram_wd_sel = 1.
  - The RAM captures on the Clk edge.
  - A write with be = 00 is still granted, but ram_wen = 00.
- Granted read:
  - ram_ra = addr; ram_wen = 00; ram_wd_sel = 0.
  - The rd-issued flag and owner bit are registered.
  - Next cycle: ram_rd_sel = 1, rdata = ram_rd, and the owner's rvalid = 1, for exactly one cycle.
  - Latency is 1 cycle, so back-to-back reads give back-to-back rvalid.
- Idle: ram_wa, ram_ra and ram_wd may hold their last values. ram_wen = 0 and ram_wd_sel = 0.
- rdata is 0 whenever no rvalid is asserted.
- Same-address write then read on consecutive cycles returns the new data; the RAM write completes at the first edge.
- Reset mid-operation: a pending rvalid is suppressed (it is 0 the cycle after Rst) and the pointer returns to A. Requesters must reissue.
- A requester must hold req and its payload until it sees gnt. Dropping req before the grant is allowed and has no side effect.

Optional Feature:
- Macro: SDIO_RAM_ARB_LOCK_EN.
- When defined, ports a_lock and b_lock (input, 1 bit) are added.
  - While the current owner holds req and lock, it keeps the grant regardless of the other port, and the pointer does not rotate.
  - The lock counter increments on each locked grant. At MAX_LOCK consecutive locked grants, the next cycle is forced to the other port if it is requesting, and the counter clears.
  - The counter also clears when lock drops or the owner changes.
- When not defined: no lock ports, no counter, pure round-robin.

Decomposition:
- Package sdio_ram_pkg:
  - AW/DW defaults and MAX_LOCK default.
  - Port-ID constants PORT_A = 0, PORT_B = 1.
  - Byte-enable constants BE_NONE, BE_LO, BE_HI, BE_ALL.
- One natural sub-module: sdio_ram_rr_arb, a two-way round-robin grant with pointer (and lock counter under the macro). The top wraps it with the RAM mux and read-return pipeline.

Test Plan:
- Rst high 2 cycles with a_req = 1 -> a_gnt = 0, ram_wen = 00, a_rvalid = b_rvalid = 0. After release, A granted first.
- A writes addr 0x10, data 0x2ABCD, be = 11, then A reads 0x10 -> next-cycle a_rvalid = 1, rdata = 0x2ABCD.
- A and B both request continuously for 6 cycles -> grants alternate A, B, A, B, A, B. No double grant.
- A write 0x05 with be = 01, data 0x3FFFF over prior 0x00000 -> read returns 0x001FF.
- B read issued, Rst asserted next cycle -> b_rvalid stays 0, pointer back to A.
- With SDIO_RAM_ARB_LOCK_EN, MAX_LOCK = 4: A locked, B requesting -> A granted 4 cycles, B granted on cycle 5.
